// File: rtl/reg_wen_sequencer.sv
// Register write-enable sequencer: one-hot/broadcast decode from two index sources plus a range sweep.
// Optional Hold input (freeze) is compiled in when RDEC_HOLD_EN is defined.
module reg_wen_sequencer #(
    parameter int NUM_REGS   = 19,
    parameter int SEL_W      = 5,
    parameter int BCAST_CODE = 31
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [1:0]          Src_sel,
    input  logic [SEL_W-1:0]    Idx_a,
    input  logic [SEL_W-1:0]    Idx_b,
    input  logic [SEL_W-1:0]    Sweep_first,
    input  logic [SEL_W-1:0]    Sweep_last,
    input  logic                Abort,
`ifdef RDEC_HOLD_EN
    input  logic                Hold,
`endif
    output logic                Ready,
    output logic [NUM_REGS-1:0] Enable_out,
    output logic                Done,
    output logic                Err
);

    localparam logic [SEL_W-1:0] NREG_L  = SEL_W'(NUM_REGS);
    localparam logic [SEL_W-1:0] BCAST_L = SEL_W'(BCAST_CODE);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0]    last_q, last_d;
    logic [NUM_REGS-1:0] en_q, en_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                hold;

`ifdef RDEC_HOLD_EN
    assign hold = Hold;
`else
    assign hold = 1'b0;
`endif

    function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REGS-1:0] r;
        for (int k = 0; k < NUM_REGS; k++) begin
            r[k] = (idx == SEL_W'(k + 1));
        end
        return r;
    endfunction

    function automatic logic in_range(input logic [SEL_W-1:0] idx);
        return (idx != '0) && (idx <= NREG_L);
    endfunction

    // Index 0 is a legal "no destination"; anything else outside the bank and not broadcast is an error.
    function automatic logic [NUM_REGS:0] decode(input logic [SEL_W-1:0] idx);
        logic [NUM_REGS:0] r;
        r = '0;
        if (idx == BCAST_L) begin
            r[NUM_REGS-1:0] = '1;
        end else if (in_range(idx)) begin
            r[NUM_REGS-1:0] = onehot(idx);
        end else if (idx != '0) begin
            r[NUM_REGS] = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        logic [NUM_REGS:0] dec;
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        en_d    = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        dec     = '0;
        if (Abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!hold) begin
            case (state_q)
                IDLE: begin
                    case (Src_sel)
                        2'd1: dec = decode(Idx_a);
                        2'd2: dec = decode(Idx_b);
                        2'd3: begin
                            if (in_range(Sweep_first) && in_range(Sweep_last) &&
                                (Sweep_first <= Sweep_last)) begin
                                state_d = SWEEP;
                                cnt_d   = Sweep_first;
                                last_d  = Sweep_last;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: dec = '0;
                    endcase
                    if (Src_sel == 2'd1 || Src_sel == 2'd2) begin
                        en_d  = dec[NUM_REGS-1:0];
                        err_d = dec[NUM_REGS];
                    end
                end
                SWEEP: begin
                    en_d = onehot(cnt_q);
                    // Range was validated on entry, so cnt never steps past last and cannot wrap.
                    if (cnt_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            en_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign Ready      = (state_q == IDLE) && !hold;
    assign Enable_out = en_q;
    assign Done       = done_q;
    assign Err        = err_q;

endmodule

// File: tb/tb_reg_wen_sequencer.sv
// Directed bench for reg_wen_sequencer (default build, NUM_REGS=19, SEL_W=5, BCAST_CODE=31).
module tb_reg_wen_sequencer;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic [1:0]  Src_sel;
    logic [4:0]  Idx_a, Idx_b, Sweep_first, Sweep_last;
    logic        Abort;
    logic        Ready, Done, Err;
    logic [18:0] Enable_out;

    int tests = 0;
    int fails = 0;

    reg_wen_sequencer #(.NUM_REGS(19), .SEL_W(5), .BCAST_CODE(31)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Src_sel(Src_sel), .Idx_a(Idx_a), .Idx_b(Idx_b),
        .Sweep_first(Sweep_first), .Sweep_last(Sweep_last), .Abort(Abort),
        .Ready(Ready), .Enable_out(Enable_out), .Done(Done), .Err(Err)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0]  src;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  first;
        logic [4:0]  last;
        logic        abort;
        logic [18:0] en;
        logic        err;
    } vec_t;

    vec_t vecs[15];

    task automatic check_en(input string name, input logic [18:0] act, input logic [18:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: Enable_out got %05h expected %05h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_all(input string name, input logic [18:0] en, input logic done,
                             input logic err, input logic rdy);
        check_en(name, Enable_out, en);
        check_bit({name, " Done"}, Done, done);
        check_bit({name, " Err"}, Err, err);
        check_bit({name, " Ready"}, Ready, rdy);
    endtask

    initial begin
        //            src    a      b      first  last   abort en          err
        vecs[0]  = '{2'd1, 5'd5,  5'd0,  5'd0,  5'd0,  1'b0, 19'h00010, 1'b0};
        vecs[1]  = '{2'd0, 5'd5,  5'd0,  5'd0,  5'd0,  1'b0, 19'h00000, 1'b0};
        vecs[2]  = '{2'd2, 5'd7,  5'd19, 5'd0,  5'd0,  1'b0, 19'h40000, 1'b0};
        vecs[3]  = '{2'd1, 5'd31, 5'd0,  5'd0,  5'd0,  1'b0, 19'h7FFFF, 1'b0};
        vecs[4]  = '{2'd1, 5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 19'h00000, 1'b0};
        vecs[5]  = '{2'd1, 5'd25, 5'd0,  5'd0,  5'd0,  1'b0, 19'h00000, 1'b1};
        vecs[6]  = '{2'd0, 5'd25, 5'd0,  5'd0,  5'd0,  1'b0, 19'h00000, 1'b0};
        vecs[7]  = '{2'd1, 5'd5,  5'd0,  5'd0,  5'd0,  1'b1, 19'h00000, 1'b0};
        vecs[8]  = '{2'd3, 5'd0,  5'd0,  5'd8,  5'd4,  1'b0, 19'h00000, 1'b1};
        vecs[9]  = '{2'd3, 5'd0,  5'd0,  5'd0,  5'd5,  1'b0, 19'h00000, 1'b1};
        vecs[10] = '{2'd3, 5'd0,  5'd0,  5'd3,  5'd20, 1'b0, 19'h00000, 1'b1};
        vecs[11] = '{2'd2, 5'd0,  5'd1,  5'd0,  5'd0,  1'b0, 19'h00001, 1'b0};
        vecs[12] = '{2'd1, 5'd20, 5'd0,  5'd0,  5'd0,  1'b0, 19'h00000, 1'b1};
        vecs[13] = '{2'd2, 5'd0,  5'd30, 5'd0,  5'd0,  1'b0, 19'h00000, 1'b1};
        vecs[14] = '{2'd3, 5'd0,  5'd0,  5'd19, 5'd19, 1'b1, 19'h00000, 1'b0};

        Reset_n = 1'b0; Src_sel = 2'd0; Idx_a = '0; Idx_b = '0;
        Sweep_first = '0; Sweep_last = '0; Abort = 1'b0;
        step();
        step();
        check_all("reset", 19'h0, 1'b0, 1'b0, 1'b1);
        Reset_n = 1'b1;
        step();
        check_all("post-reset idle", 19'h0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 15; i++) begin
            Src_sel = vecs[i].src; Idx_a = vecs[i].a; Idx_b = vecs[i].b;
            Sweep_first = vecs[i].first; Sweep_last = vecs[i].last; Abort = vecs[i].abort;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].en, 1'b0, vecs[i].err, 1'b1);
        end
        Src_sel = 2'd0; Abort = 1'b0;
        step();
        check_all("idle after table", 19'h0, 1'b0, 1'b0, 1'b1);

        // Sweep 3..6 with a request presented mid-sweep that must be ignored
        Src_sel = 2'd3; Sweep_first = 5'd3; Sweep_last = 5'd6;
        step();
        check_all("sweep accept", 19'h0, 1'b0, 1'b0, 1'b0);
        Src_sel = 2'd1; Idx_a = 5'd10;
        step();
        check_all("sweep i3", 19'h00004, 1'b0, 1'b0, 1'b0);
        step();
        check_all("sweep i4", 19'h00008, 1'b0, 1'b0, 1'b0);
        Src_sel = 2'd0;
        step();
        check_all("sweep i5", 19'h00010, 1'b0, 1'b0, 1'b0);
        step();
        check_all("sweep i6 done", 19'h00020, 1'b1, 1'b0, 1'b1);
        step();
        check_all("sweep end idle", 19'h0, 1'b0, 1'b0, 1'b1);

        // Single-element sweep
        Src_sel = 2'd3; Sweep_first = 5'd19; Sweep_last = 5'd19;
        step();
        Src_sel = 2'd0;
        check_all("sweep1 accept", 19'h0, 1'b0, 1'b0, 1'b0);
        step();
        check_all("sweep1 done", 19'h40000, 1'b1, 1'b0, 1'b1);

        // Abort on the 2nd sweep cycle of 1..10
        Src_sel = 2'd3; Sweep_first = 5'd1; Sweep_last = 5'd10;
        step();
        Src_sel = 2'd0;
        step();
        check_all("abort sweep i1", 19'h00001, 1'b0, 1'b0, 1'b0);
        Abort = 1'b1;
        step();
        check_all("abort applied", 19'h0, 1'b0, 1'b0, 1'b1);
        Abort = 1'b0;
        step();
        check_all("abort stays idle", 19'h0, 1'b0, 1'b0, 1'b1);

        // Async reset mid-sweep at cnt=7
        Src_sel = 2'd3; Sweep_first = 5'd1; Sweep_last = 5'd15;
        step();
        Src_sel = 2'd0;
        for (int k = 1; k <= 6; k++) step();
        check_en("pre-reset i6", Enable_out, 19'h00020);
        Reset_n = 1'b0;
        #1;
        check_en("async reset en", Enable_out, 19'h0);
        check_bit("async reset Ready", Ready, 1'b1);
        step();
        Reset_n = 1'b1;
        step();
        check_all("after reset 1", 19'h0, 1'b0, 1'b0, 1'b1);
        step();
        check_all("after reset 2", 19'h0, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
